ecall_tx_buffer: RTL and testbench
==================================

Name: ecall_tx_buffer

Overview:
- Upstream feeder for the UART Avalon-MM master that sends CPU results.
- Captures 32-bit ecall result words strobed by the CPU core and buffers them in a FIFO.
- Serializes each word into a byte stream, MSB first, using a valid/ready handshake.
- The UART master drains one byte per TX-ready slot, so CPU progress is decoupled from UART throughput.

Parameters:
DEPTH, 16, number of 32-bit words the FIFO holds; must be a power of 2 and ≥2.

Ports:
avm_clk  in  1  clock; all state updates on the rising edge
avm_rst  in  1  reset; synchronous, active-high
i_ecall_ready  in  1  one-cycle strobe from the CPU; i_ecall_data is valid this cycle
i_ecall_data  in  32  result word from the CPU
o_byte_valid  out  1  o_byte_data holds a byte for the UART master
o_byte_data  out  8  current byte
i_byte_ready  in  1  UART master accepts the byte this cycle
o_count  out  $clog2(DEPTH)+1  words held in the FIFO, excluding the word in the serializer
o_overflow  out  1  sticky flag; a word was dropped
i_clear_overflow  in  1  clears o_overflow
o_idle  out  1  FIFO empty and serializer in S_IDLE

Behaviour:
- Reset (synchronous, active-high, avm_rst sampled on avm_clk):
  - FIFO pointers, o_count, o_overflow, o_byte_valid and o_byte_data all go to 0; serializer goes to S_IDLE; o_idle=1.
  - Reset mid-word discards the word in the serializer and all FIFO contents.
- Push:
  - Accept when i_ecall_ready=1 and the registered o_count<DEPTH.
  - Full is evaluated on the registered count. A push while full is dropped even if a pop occurs in the same cycle.
- Overflow:
  - A dropped push sets o_overflow on the next edge.
  - i_clear_overflow clears it. If a set and a clear occur in the same cycle, set wins.
- Pop: occurs only when the serializer loads a word. Push and pop in the same cycle (not full) leaves o_count unchanged.
- Serializer FSM:
  - S_IDLE: o_byte_valid=0. If o_count>0: pop the head into a 32-bit shift register, byte_idx=0, go to S_SEND.
  - S_SEND: o_byte_valid=1 and o_byte_data=shift[31:24].
    - On o_byte_valid&&i_byte_ready: shift<<=8 and byte_idx++.
    - On the handshake of the last byte (byte_idx==3): if the FIFO is non-empty, pop the next word and stay in S_SEND with no bubble; else go to S_IDLE.
  - While o_byte_valid=1 and i_byte_ready=0, o_byte_data and o_byte_valid hold stable.
  - i_byte_ready while o_byte_valid=0 is ignored.
- Latency: a push at cycle t into an empty, idle block gives o_count=1 at t+1, pop at t+1, and o_byte_valid=1 at t+2.
- Throughput: with i_byte_ready held at 1, one byte per cycle, continuous across words.
- o_idle is combinational: (o_count==0) && S_IDLE.

Optional Feature:
ECALL_ASCII_HEX_EN:
- Defined: each word is emitted as 9 bytes.
  - 8 ASCII hex characters, most-significant nibble first: 0-9 map to 0x30-0x39, a-f map to 0x61-0x66 (lowercase).
  - Then 0x0A.
  - byte_idx counts 0..8; the last-byte condition is byte_idx==8.
  - Nibble selection comes from the held word, not a shifted copy.
- Undefined: raw 4-byte MSB-first behaviour as above. The ASCII encoder logic is absent.

Test Plan:
1. Reset, push 0xDEADBEEF at t, i_byte_ready=1 -> o_byte_valid rises at t+2; bytes DE,AD,BE,EF on consecutive cycles; o_idle=1 afterwards; o_count=0.
2. Backpressure: same word, hold i_byte_ready=0 for 5 cycles while 0xAD is presented -> o_byte_data stays 0xAD with valid=1; sequence completes DE,AD,BE,EF with no loss or duplication.
3. Back-to-back: push 0x11223344 and 0x55667788 on consecutive cycles, ready=1 -> 8 bytes 11,22,33,44,55,66,77,88 on 8 consecutive cycles, no bubble between words.
4. Overflow (DEPTH=16): ready=0; push word 0, wait 2 cycles, then push 17 words (1..17) -> o_count=16, word 17 dropped, o_overflow=1.
   - Assert i_clear_overflow in the same cycle as another dropped push -> o_overflow stays 1.
   - Clear again alone -> o_overflow=0.
   - Release ready -> 68 bytes for words 0..16 in order.
5. Reset mid-operation: 3 words queued, serializer on byte 2 -> assert avm_rst one cycle -> next cycle o_byte_valid=0, o_count=0, o_idle=1; a fresh push of 0xCAFEF00D emits CA,FE,F0,0D.
6. With ECALL_ASCII_HEX_EN: push 0x00A5F01C -> bytes 30,30,61,35,66,30,31,63,0A; two words back-to-back -> 18 bytes, no bubble.

Source files
------------

// File: rtl/ecall_tx_buffer.sv
// ecall result buffer: FIFO of 32-bit CPU words serialized MSB-first into a byte stream.
// Optional ECALL_ASCII_HEX_EN: each word goes out as 8 lowercase hex characters plus 0x0A.
module ecall_tx_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     avm_clk,
    input  logic                     avm_rst,
    input  logic                     i_ecall_ready,
    input  logic [31:0]              i_ecall_data,
    output logic                     o_byte_valid,
    output logic [7:0]               o_byte_data,
    input  logic                     i_byte_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    input  logic                     i_clear_overflow,
    output logic                     o_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef ECALL_ASCII_HEX_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd3;
`endif

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic [3:0]    byte_idx;
    // Raw mode: shift register. ASCII mode: held word the nibbles are picked from.
    logic [31:0]   word_q;

    logic          full;
    logic          empty;
    logic          push;
    logic          drop;
    logic          handshake;
    logic          last_hs;
    logic          pop;
    logic [31:0]   head;
    logic [7:0]    load_byte;
    logic [7:0]    next_byte;
    logic [31:0]   next_word;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = i_ecall_ready && !full;
    assign drop      = i_ecall_ready && full;
    assign handshake = o_byte_valid && i_byte_ready;
    assign last_hs   = handshake && (byte_idx == LAST_IDX);
    assign pop       = !empty && ((state == S_IDLE) || last_hs);
    assign head      = mem[rd_ptr];

    assign o_count = count;
    assign o_idle  = empty && (state == S_IDLE);

`ifdef ECALL_ASCII_HEX_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [3:0] nib_at(input logic [31:0] w, input logic [3:0] idx);
        logic [3:0] n;
        case (idx)
            4'd0:    n = w[31:28];
            4'd1:    n = w[27:24];
            4'd2:    n = w[23:20];
            4'd3:    n = w[19:16];
            4'd4:    n = w[15:12];
            4'd5:    n = w[11:8];
            4'd6:    n = w[7:4];
            default: n = w[3:0];
        endcase
        return n;
    endfunction

    always_comb begin
        load_byte = hex_char(head[31:28]);
        next_byte = (byte_idx == LAST_IDX - 4'd1) ? 8'h0A
                                                  : hex_char(nib_at(word_q, byte_idx + 4'd1));
        next_word = word_q;
    end
`else
    always_comb begin
        load_byte = head[31:24];
        next_byte = word_q[23:16];
        next_word = {word_q[23:0], 8'h00};
    end
`endif

    always_ff @(posedge avm_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_ecall_data;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clear_overflow) begin
            o_overflow <= 1'b0;
        end
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state        <= S_IDLE;
            o_byte_valid <= 1'b0;
            o_byte_data  <= '0;
            byte_idx     <= '0;
            word_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state        <= S_SEND;
                        o_byte_valid <= 1'b1;
                        o_byte_data  <= load_byte;
                        byte_idx     <= '0;
                        word_q       <= head;
                    end
                end
                S_SEND: begin
                    if (handshake) begin
                        if (last_hs) begin
                            if (pop) begin
                                o_byte_data <= load_byte;
                                byte_idx    <= '0;
                                word_q      <= head;
                            end else begin
                                state        <= S_IDLE;
                                o_byte_valid <= 1'b0;
                                byte_idx     <= '0;
                            end
                        end else begin
                            o_byte_data <= next_byte;
                            byte_idx    <= byte_idx + 4'd1;
                            word_q      <= next_word;
                        end
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    o_byte_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecall_tx_buffer.sv
// Testbench for ecall_tx_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_ecall_tx_buffer;

    localparam int DEPTH = 16;

    logic                   avm_clk = 1'b0;
    logic                   avm_rst;
    logic                   i_ecall_ready;
    logic [31:0]            i_ecall_data;
    logic                   o_byte_valid;
    logic [7:0]             o_byte_data;
    logic                   i_byte_ready;
    logic [$clog2(DEPTH):0] o_count;
    logic                   o_overflow;
    logic                   i_clear_overflow;
    logic                   o_idle;

    ecall_tx_buffer #(.DEPTH(DEPTH)) dut (
        .avm_clk          (avm_clk),
        .avm_rst          (avm_rst),
        .i_ecall_ready    (i_ecall_ready),
        .i_ecall_data     (i_ecall_data),
        .o_byte_valid     (o_byte_valid),
        .o_byte_data      (o_byte_data),
        .i_byte_ready     (i_byte_ready),
        .o_count          (o_count),
        .o_overflow       (o_overflow),
        .i_clear_overflow (i_clear_overflow),
        .o_idle           (o_idle)
    );

    always #5 avm_clk = ~avm_clk;

    int vectors    = 0;
    int miscompares = 0;

    // Model: words waiting in the FIFO, and bytes still to be sent from the word in flight.
    logic [31:0] fifo_q [$];
    logic [7:0]  cur_q  [$];
    logic        m_ovf;

    function automatic logic [7:0] hex_ascii(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(97 + n - 10);
    endfunction

    task automatic load_word();
        logic [31:0] w;
        w = fifo_q.pop_front();
`ifdef ECALL_ASCII_HEX_EN
        for (int k = 7; k >= 0; k--) cur_q.push_back(hex_ascii(int'((w >> (4 * k)) & 32'hF)));
        cur_q.push_back(8'h0A);
`else
        for (int k = 3; k >= 0; k--) cur_q.push_back(8'((w >> (8 * k)) & 32'hFF));
`endif
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic er, input logic [31:0] d,
                        input logic br, input logic clr);
        int n;
        avm_rst          = rst;
        i_ecall_ready    = er;
        i_ecall_data     = d;
        i_byte_ready     = br;
        i_clear_overflow = clr;
        @(posedge avm_clk);
        if (rst) begin
            fifo_q.delete();
            cur_q.delete();
            m_ovf = 1'b0;
        end else begin
            n = fifo_q.size();
            if (cur_q.size() == 0) begin
                if (n > 0) load_word();
            end else if (br) begin
                void'(cur_q.pop_front());
                if (cur_q.size() == 0 && n > 0) load_word();
            end
            if (er) begin
                if (n < DEPTH) fifo_q.push_back(d);
                else           m_ovf = 1'b1;
            end else if (clr) begin
                m_ovf = 1'b0;
            end
            if (er && n >= DEPTH) m_ovf = 1'b1;
            else if (clr && !(er && n >= DEPTH)) m_ovf = 1'b0;
        end
        #1;
        check("valid", {31'd0, o_byte_valid}, {31'd0, cur_q.size() > 0});
        if (cur_q.size() > 0) check("data", {24'd0, o_byte_data}, {24'd0, cur_q[0]});
        check("count", 32'(o_count), 32'(fifo_q.size()));
        check("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
        check("idle", {31'd0, o_idle}, {31'd0, (fifo_q.size() == 0) && (cur_q.size() == 0)});
    endtask

    task automatic idle_cycles(input int n, input logic br);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, br, 1'b0);
    endtask

    initial begin
        int pe;
        int pb;
        avm_rst = 1'b1; i_ecall_ready = 1'b0; i_ecall_data = '0;
        i_byte_ready = 1'b0; i_clear_overflow = 1'b0; m_ovf = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        check("reset_data", {24'd0, o_byte_data}, 32'd0);

        // Single word, ready held high
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        idle_cycles(8, 1'b1);

        // Backpressure while the second byte is presented
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        idle_cycles(2, 1'b1);
        idle_cycles(5, 1'b0);
        idle_cycles(6, 1'b1);

        // Back-to-back words, no bubble
        step(1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h55667788, 1'b1, 1'b0);
        idle_cycles(22, 1'b1);

        // Overflow, set-beats-clear, clear alone, then drain
        step(1'b0, 1'b1, 32'd0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        for (int w = 1; w <= 17; w++) step(1'b0, 1'b1, 32'(w), 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'd18, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        idle_cycles(160, 1'b1);

        // Reset in the middle of a word with words queued
        for (int w = 0; w < 4; w++) step(1'b0, 1'b1, 32'hA0000000 + 32'(w), 1'b0, 1'b0);
        idle_cycles(2, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        idle_cycles(12, 1'b1);

        // Hex-pattern word, then two words back-to-back
        step(1'b0, 1'b1, 32'h00A5F01C, 1'b1, 1'b0);
        idle_cycles(12, 1'b1);
        step(1'b0, 1'b1, 32'h89ABCDEF, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h01234567, 1'b1, 1'b0);
        idle_cycles(22, 1'b1);

        // Random traffic with varying push/drain pressure
        pe = 30; pb = 75;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                pe = $urandom_range(5, 95);
                pb = $urandom_range(5, 100);
            end
            step($urandom_range(0, 699) == 0,
                 $urandom_range(0, 99) < pe,
                 $urandom,
                 $urandom_range(0, 99) < pb,
                 $urandom_range(0, 49) == 0);
        end
        idle_cycles(200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
